// File: rtl/idi_req_queue.sv
// idi_req_queue: IDI request FIFO in front of the IDI-to-AXI bridge.
// Filters out-of-range addresses, gates reads, registers read responses.
module idi_req_queue #(
   parameter int DEPTH  = 4,
   parameter int MAX_RD = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic                       s_is_write,
   input  logic [63:0]                s_addr,
   input  logic [31:0]                s_wdata,
   output logic [31:0]                s_rdata,
   output logic                       s_rvalid,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_is_write,
   output logic [63:0]                m_addr,
   output logic [31:0]                m_wdata,
   input  logic [31:0]                m_rdata,
   input  logic                       m_rvalid,
   output logic [$clog2(DEPTH):0]     count,
   output logic [3:0]                 rd_out,
   output logic [7:0]                 err_cnt,
   output logic                       rsp_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic          mem_wr [DEPTH];
   logic [63:0]   mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          full;
   logic          empty;
   logic          accept;
   logic          keep;
   logic          filt;
   logic          pop;
   logic          rd_pop;

   assign count  = wr_ptr - rd_ptr;
   assign full   = (count == CW'(DEPTH));
   assign empty  = (count == '0);

   assign s_ready = !full && !rst;
   assign accept  = s_valid && s_ready;
   assign keep    = accept && (s_addr[63:32] == 32'd0);
   assign filt    = accept && (s_addr[63:32] != 32'd0);

   assign m_is_write = mem_wr[rd_ptr[AW-1:0]];
   assign m_addr     = mem_addr[rd_ptr[AW-1:0]];
   assign m_wdata    = mem_data[rd_ptr[AW-1:0]];

   // head may issue unless it is a read and the read budget is used up
   assign m_valid = !rst && !empty &&
                    (m_is_write || (rd_out < 4'(MAX_RD)));
   assign pop     = m_valid && m_ready;
   assign rd_pop  = pop && !m_is_write;

   // entry storage, written only for in-range requests
   always_ff @(posedge clk) begin
      if (keep) begin
         mem_wr[wr_ptr[AW-1:0]]   <= s_is_write;
         mem_addr[wr_ptr[AW-1:0]] <= s_addr;
         mem_data[wr_ptr[AW-1:0]] <= s_wdata;
      end
   end

   // FIFO pointers, MSB distinguishes full from empty
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (keep) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // saturating count of filtered requests
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (filt && err_cnt != 8'hFF)
         err_cnt <= err_cnt + 8'd1;
   end

   // outstanding reads; a response with nothing outstanding is flagged
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_out  <= '0;
         rsp_ovf <= 1'b0;
      end else if (rd_pop && !m_rvalid) begin
         rd_out <= rd_out + 4'd1;
      end else if (!rd_pop && m_rvalid) begin
         if (rd_out == 4'd0)
            rsp_ovf <= 1'b1;
         else
            rd_out <= rd_out - 4'd1;
      end
   end

   // one-cycle response register back to the requester
   always_ff @(posedge clk) begin
      if (rst) begin
         s_rvalid <= 1'b0;
         s_rdata  <= '0;
      end else begin
         s_rvalid <= m_rvalid;
         if (m_rvalid) s_rdata <= m_rdata;
      end
   end

endmodule

// File: tb/tb_idi_req_queue.sv
// tb_idi_req_queue: scoreboard bench for idi_req_queue.
// Expected bridge requests and responses are queued by stimulus, checked by a monitor.
module tb_idi_req_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic        s_is_write;
   logic [63:0] s_addr;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata;
   logic        s_rvalid;
   logic        m_valid;
   logic        m_ready;
   logic        m_is_write;
   logic [63:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_rvalid;
   logic [2:0]  count;
   logic [3:0]  rd_out;
   logic [7:0]  err_cnt;
   logic        rsp_ovf;

   typedef struct packed {
      logic        wr;
      logic [63:0] addr;
      logic [31:0] data;
   } req_t;

   req_t        mq[$];
   logic [31:0] rq[$];
   int          vectors = 0;
   int          miscompares = 0;

   idi_req_queue #(.DEPTH(4), .MAX_RD(2)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready),
      .s_is_write(s_is_write), .s_addr(s_addr),
      .s_wdata(s_wdata), .s_rdata(s_rdata),
      .s_rvalid(s_rvalid),
      .m_valid(m_valid), .m_ready(m_ready),
      .m_is_write(m_is_write), .m_addr(m_addr),
      .m_wdata(m_wdata), .m_rdata(m_rdata),
      .m_rvalid(m_rvalid),
      .count(count), .rd_out(rd_out),
      .err_cnt(err_cnt), .rsp_ovf(rsp_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // issue one request; exp_out queues it as a future bridge request
   task automatic push(input logic w, input logic [63:0] a,
                       input logic [31:0] d, input logic exp_out);
      int n = 0;
      s_valid = 1'b1; s_is_write = w; s_addr = a; s_wdata = d;
      while (!s_ready && n < 20) begin
         tick();
         n++;
      end
      if (n == 20) begin
         chk("push_timeout", 64'd0, 64'd1);
      end else begin
         if (exp_out) mq.push_back('{wr: w, addr: a, data: d});
         tick();
      end
      s_valid = 1'b0;
   endtask

   task automatic rsp(input logic [31:0] d);
      m_rvalid = 1'b1;
      m_rdata  = d;
      rq.push_back(d);
      tick();
      m_rvalid = 1'b0;
   endtask

   // monitor: compares every bridge pop and every upstream response
   always @(negedge clk) begin
      if (m_valid && m_ready) begin
         if (mq.size() == 0) begin
            chk("unexpected_pop", {32'd0, m_addr[31:0]}, 64'hFFFF_FFFF);
         end else begin
            req_t e;
            e = mq.pop_front();
            chk("pop_wr", {63'd0, m_is_write}, {63'd0, e.wr});
            chk("pop_addr", m_addr, e.addr);
            if (e.wr) chk("pop_wdata", {32'd0, m_wdata}, {32'd0, e.data});
         end
      end
      if (s_rvalid) begin
         if (rq.size() == 0) begin
            chk("unexpected_rsp", {32'd0, s_rdata}, 64'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = rq.pop_front();
            chk("rsp_data", {32'd0, s_rdata}, {32'd0, e});
         end
      end
   end

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_is_write = 1'b0; s_addr = '0;
      s_wdata = '0; m_ready = 1'b0; m_rdata = '0; m_rvalid = 1'b0;
      tick();
      tick();
      chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
      chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
      chk("rst_s_rvalid", {63'd0, s_rvalid}, 64'd0);
      chk("rst_s_rdata", {32'd0, s_rdata}, 64'd0);
      chk("rst_count", {61'd0, count}, 64'd0);
      chk("rst_rd_out", {60'd0, rd_out}, 64'd0);
      chk("rst_err_cnt", {56'd0, err_cnt}, 64'd0);
      chk("rst_rsp_ovf", {63'd0, rsp_ovf}, 64'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);

      // single write, visible one cycle after accept, popped immediately
      m_ready = 1'b1;
      push(1'b1, 64'h100, 32'hDEADBEEF, 1'b1);
      chk("t1_m_valid", {63'd0, m_valid}, 64'd1);
      chk("t1_m_addr", m_addr, 64'h100);
      tick();
      chk("t1_count", {61'd0, count}, 64'd0);
      chk("t1_m_valid_after", {63'd0, m_valid}, 64'd0);

      // fill, then drain in order
      m_ready = 1'b0;
      push(1'b1, 64'h10, 32'h1111_0001, 1'b1);
      push(1'b1, 64'h14, 32'h1111_0002, 1'b1);
      push(1'b1, 64'h18, 32'h1111_0003, 1'b1);
      push(1'b1, 64'h1C, 32'h1111_0004, 1'b1);
      chk("t2_s_ready_full", {63'd0, s_ready}, 64'd0);
      chk("t2_count_full", {61'd0, count}, 64'd4);
      m_ready = 1'b1;
      tick();
      chk("t2_s_ready_after_pop", {63'd0, s_ready}, 64'd1);
      chk("t2_count_3", {61'd0, count}, 64'd3);
      repeat (3) tick();
      chk("t2_count_drained", {61'd0, count}, 64'd0);

      // read gating at MAX_RD
      push(1'b0, 64'h200, 32'd0, 1'b1);
      push(1'b0, 64'h204, 32'd0, 1'b1);
      push(1'b0, 64'h208, 32'd0, 1'b1);
      chk("t3_rd_out_2", {60'd0, rd_out}, 64'd2);
      chk("t3_gated", {63'd0, m_valid}, 64'd0);
      chk("t3_count_1", {61'd0, count}, 64'd1);
      rsp(32'h12345678);
      chk("t3_rd_out_1", {60'd0, rd_out}, 64'd1);
      chk("t3_ungated", {63'd0, m_valid}, 64'd1);
      tick();
      chk("t3_rd_out_2b", {60'd0, rd_out}, 64'd2);
      rsp(32'h0000_00A1);
      rsp(32'h0000_00B2);
      tick();
      chk("t3_rd_out_0", {60'd0, rd_out}, 64'd0);

      // filtered requests
      push(1'b0, 64'h1_0000_0100, 32'd0, 1'b0);
      chk("t4_s_ready", {63'd0, s_ready}, 64'd1);
      chk("t4_err_1", {56'd0, err_cnt}, 64'd1);
      chk("t4_count", {61'd0, count}, 64'd0);
      for (int i = 0; i < 299; i++)
         push(1'b1, 64'h1_0000_0100, 32'd5, 1'b0);
      chk("t4_err_sat", {56'd0, err_cnt}, 64'd255);

      // response with nothing outstanding
      rsp(32'hCAFE0001);
      chk("t5_rsp_ovf", {63'd0, rsp_ovf}, 64'd1);
      chk("t5_rd_out", {60'd0, rd_out}, 64'd0);
      repeat (3) tick();
      chk("t5_rsp_ovf_sticky", {63'd0, rsp_ovf}, 64'd1);

      // reset mid-operation
      push(1'b0, 64'h300, 32'd0, 1'b1);
      tick();
      m_ready = 1'b0;
      push(1'b1, 64'h400, 32'h4444_0000, 1'b0);
      push(1'b1, 64'h404, 32'h4444_0004, 1'b0);
      chk("t6_count_2", {61'd0, count}, 64'd2);
      chk("t6_rd_out_1", {60'd0, rd_out}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("t6_count_0", {61'd0, count}, 64'd0);
      chk("t6_rd_out_0", {60'd0, rd_out}, 64'd0);
      chk("t6_m_valid", {63'd0, m_valid}, 64'd0);
      chk("t6_rsp_ovf_clr", {63'd0, rsp_ovf}, 64'd0);
      chk("t6_err_clr", {56'd0, err_cnt}, 64'd0);
      rsp(32'h0BADF00D);
      chk("t6_late_ovf", {63'd0, rsp_ovf}, 64'd1);
      chk("t6_late_rd_out", {60'd0, rd_out}, 64'd0);
      repeat (2) tick();

      chk("mq_empty", 64'(mq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/idi_req_queue.md
# idi_req_queue

Request buffer between the IDI request source and the IDI-to-AXI bridge. Accepts IDI read/write requests on an upstream valid/ready port and stores them in a DEPTH-entry FIFO. Presents them in order to the bridge, drops requests whose address does not fit the 32-bit AXI space, and limits outstanding reads. Read data returned by the bridge goes back upstream through a one-cycle register.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- MAX_RD, 2, maximum reads issued to the bridge and not yet answered; 1..15

- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_valid  input  1  upstream request valid
- s_ready  output  1  queue can accept a request
- s_is_write  input  1  1 = write, 0 = read
- s_addr  input  64  request byte address
- s_wdata  input  32  write data
- s_rdata  output  32  read data returned upstream
- s_rvalid  output  1  one-cycle pulse, s_rdata valid
- m_valid  output  1  request to bridge valid
- m_ready  input  1  bridge accepts request
- m_is_write  output  1  head entry type
- m_addr  output  64  head entry address
- m_wdata  output  32  head entry write data
- m_rdata  input  32  bridge read data
- m_rvalid  input  1  bridge read data valid (one pulse per read)
- count  output  $clog2(DEPTH)+1  entries currently stored
- rd_out  output  4  reads outstanding at the bridge
- err_cnt  output  8  filtered-request counter, saturating
- rsp_ovf  output  1  sticky: m_rvalid seen with rd_out == 0

## Operation
- Storage: circular array of {is_write, addr, wdata}, DEPTH entries. wr_ptr/rd_ptr are $clog2(DEPTH)+1 bits, so the MSB distinguishes full from empty. Pointers wrap modulo 2*DEPTH.
- full = (count == DEPTH); empty = (count == 0).
- s_ready = !full && !rst.
- Accept: s_valid && s_ready.
  - If s_addr[63:32] == 0: write the entry at wr_ptr and increment wr_ptr.
  - Otherwise, filter: the request is consumed (handshake completes) but not stored. err_cnt increments and saturates at 255. No response is generated for filtered reads.
- Issue gating: m_valid = !empty && (head is write || rd_out < MAX_RD). m_is_write, m_addr and m_wdata always reflect the head entry, and hold stable while m_valid is high and m_ready is low.
- Pop: m_valid && m_ready; rd_ptr increments.
- rd_out update per cycle:
  - +1 when a read is popped.
  - -1 on m_rvalid.
  - Both in the same cycle: unchanged.
  - m_rvalid while rd_out == 0 (and no read popped that cycle): rd_out stays 0 and rsp_ovf sets. rsp_ovf clears only on rst.
- Response: s_rvalid <= m_rvalid. s_rdata <= m_rdata when m_rvalid is high; otherwise s_rdata holds its previous value.
- Simultaneous push and pop is allowed and leaves count unchanged. Push and pop together while full cannot occur, because s_ready is 0 when full.
- No bypass: a request pushed into an empty queue is never visible on m_* in the same cycle.

## Timing
- Reset values:
  - All pointers, count, rd_out, err_cnt and rsp_ovf = 0.
  - s_rvalid = 0, s_rdata = 0, m_valid = 0, s_ready = 0 while rst is high.
  - s_ready = 1 in the first cycle after rst deasserts.
- Reset mid-operation discards all stored entries and the outstanding-read count. Responses from the bridge for reads issued before reset are still forwarded on s_rvalid but do not change rd_out; if rd_out == 0 when they arrive, rsp_ovf sets.
- Latency, accept to m_valid: 1 cycle into an empty queue, with no read gating.
- Latency, m_rvalid to s_rvalid: exactly 1 cycle.
- Sustained throughput: 1 request/cycle in and out when m_ready is held high and only writes are queued.
- Ordering: strict FIFO. A gated read at the head blocks writes behind it; no reordering.
- count, rd_out and err_cnt are registered and reflect the state after the previous edge.

## Test plan
- Reset, then write 0x100/0xDEADBEEF with m_ready = 1 → m_valid high the next cycle with m_addr = 0x100 and m_wdata = 0xDEADBEEF; popped the same cycle; count returns to 0.
- With m_ready = 0, push DEPTH writes → s_ready = 0 and count = 4. Raise m_ready → entries leave in push order, and s_ready = 1 one cycle after the first pop.
- Push 3 reads with MAX_RD = 2 and no m_rvalid → 2 reads issue, m_valid drops with the third at the head, rd_out = 2. Pulse m_rvalid with m_rdata = 0x12345678 → s_rvalid pulses the next cycle with s_rdata = 0x12345678, and the third read issues.
- Request with addr = 0x1_0000_0100 → accepted (s_ready stays 1), never appears on m_*, err_cnt = 1. Send 300 such requests → err_cnt = 255.
- m_rvalid with rd_out = 0 → rsp_ovf = 1 and stays set until rst; rd_out stays 0.
- Assert rst with 2 entries queued and 1 read outstanding → the next cycle count = 0, rd_out = 0, m_valid = 0; a late m_rvalid is forwarded on s_rvalid and sets rsp_ovf.
